map_ss_reader: RTL and testbench

MAP_SS_READER -- requirements
Module: map_ss_reader

---
 rtl/map_ss_reader_pkg.sv | 30 +++
 rtl/ss_fifo.sv | 46 ++++
 rtl/map_ss_reader.sv | 134 +++++++++++++
 tb/tb_map_ss_reader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_ss_reader_pkg.sv
// Shared definitions for the save-state reader: widths, FSM encoding and CRC-8 constants.
package map_ss_reader_pkg;

  localparam int unsigned BW_SS_CTRL = 8;
  localparam int unsigned BwSsAddr   = BW_SS_CTRL;
  localparam int unsigned BwSsData   = BW_SS_CTRL;
  localparam int unsigned BwSsCnt    = 9;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCapt,
    StFin
  } ss_state_e;

  localparam logic [7:0] Crc8Poly = 8'h07;
  localparam logic [7:0] Crc8Init = 8'hFF;

  // MSB-first CRC-8 over one byte.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ Crc8Poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ss_fifo.sv
// Small synchronous FIFO with registered storage, flush and occupancy count.
module ss_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             pop;

  assign pop = pop_i && (cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/map_ss_reader.sv
// Reads SS_LEN save-state bytes from a mapper into an output FIFO, one read in flight at a time.
// Define SS_READER_CRC_EN to add a CRC-8 of the dumped bytes on port crc.
module map_ss_reader
  import map_ss_reader_pkg::*;
#(
  parameter int unsigned SS_LEN     = 256,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic [BwSsAddr-1:0] ss_addr,
  output logic                ss_rd,
  input  logic [BwSsData-1:0] ss_din,
  output logic [BwSsData-1:0] dout,
  output logic                dout_vld,
  input  logic                dout_rdy,
  output logic                busy,
  output logic                done
`ifdef SS_READER_CRC_EN
  ,
  output logic [7:0]          crc
`endif
);

  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;

  ss_state_e            state_q;
  logic [BwSsCnt-1:0]   cnt_q;
  logic [2:0]           wait_q;
  logic                 done_q;

  logic [FifoCntW-1:0]  fifo_cnt;
  logic [BwSsData-1:0]  fifo_head;
  logic                 fifo_vld;
  logic                 room, last, push, pop, kill;

  assign kill = rst || abort;
  assign room = (fifo_cnt < FifoCntW'(FIFO_DEPTH));
  assign last = (cnt_q == BwSsCnt'(SS_LEN - 1));
  assign push = (state_q == StCapt) && !kill;
  assign pop  = dout_vld && dout_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
    end else if (abort) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q   <= '0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (room) begin
            if (RD_LAT == 1) begin
              state_q <= StCapt;
            end else begin
              state_q <= StWait;
              wait_q  <= 3'(RD_LAT - 2);
            end
          end
        end
        StWait: begin
          if (wait_q == '0) state_q <= StCapt;
          else              wait_q  <= wait_q - 3'd1;
        end
        StCapt: begin
          if (last) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + BwSsCnt'(1);
            state_q <= StIssue;
          end
        end
        StFin: begin
          if (fifo_cnt == '0) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  ss_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (BwSsData)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (abort),
    .push_i  (push),
    .data_i  (ss_din),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .valid_o (fifo_vld),
    .count_o (fifo_cnt)
  );

  // Outputs are forced low while rst is held, not only after the reset edge.
  assign ss_rd    = (state_q == StIssue) && room && !kill;
  assign ss_addr  = rst ? '0 : cnt_q[BwSsAddr-1:0];
  assign dout     = rst ? '0 : fifo_head;
  assign dout_vld = fifo_vld && !rst;
  assign busy     = (state_q != StIdle) && !rst;
  assign done     = done_q && !rst;

`ifdef SS_READER_CRC_EN
  logic [7:0] crc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= Crc8Init;
    end else if (!abort && (state_q == StIdle) && start) begin
      crc_q <= Crc8Init;
    end else if (push) begin
      crc_q <= crc8_update(crc_q, ss_din);
    end
  end

  assign crc = crc_q;
`endif

endmodule

// File: tb/tb_map_ss_reader.sv
// Self-checking bench: two reader instances (short dump / full 256-byte dump) against
// a queue-based reference with a latency-exact mapper model and random backpressure.
module tb_map_ss_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] crc_model(input logic [7:0] q[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'hFF;
    foreach (q[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ q[i][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  // ---------------- instance A: SS_LEN=4, RD_LAT=2 ----------------
  logic       a_start = 0, a_abort = 0, a_rdy = 0, a_rnd = 0;
  logic [7:0] a_ss_addr, a_din, a_dout;
  logic       a_ss_rd, a_vld, a_busy, a_done;
  logic [7:0] a_mem [256];
  logic       a_rd1 = 0, a_rd2 = 0;
  logic [7:0] a_ad1 = 0, a_ad2 = 0;
  logic [7:0] a_rd_q[$], a_rx_q[$];
  int         a_done_n = 0;
`ifdef SS_READER_CRC_EN
  logic [7:0] a_crc, a_crc_done;
`endif

  map_ss_reader #(.SS_LEN(4), .RD_LAT(2), .FIFO_DEPTH(4)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .start    (a_start),
    .abort    (a_abort),
    .ss_addr  (a_ss_addr),
    .ss_rd    (a_ss_rd),
    .ss_din   (a_din),
    .dout     (a_dout),
    .dout_vld (a_vld),
    .dout_rdy (a_rdy),
    .busy     (a_busy),
    .done     (a_done)
`ifdef SS_READER_CRC_EN
    ,
    .crc      (a_crc)
`endif
  );

  // Mapper: data is valid only in the cycle exactly RD_LAT after the strobe cycle.
  always @(posedge clk) begin
    a_rd1 <= a_ss_rd;  a_ad1 <= a_ss_addr;
    a_rd2 <= a_rd1;    a_ad2 <= a_ad1;
  end
  assign a_din = a_rd2 ? a_mem[a_ad2] : ~a_mem[a_ad2];

  always @(negedge clk) begin
    if (a_ss_rd) a_rd_q.push_back(a_ss_addr);
    if (a_vld && a_rdy) a_rx_q.push_back(a_dout);
    if (a_done) begin
      a_done_n++;
`ifdef SS_READER_CRC_EN
      a_crc_done = a_crc;
`endif
    end
  end

  always @(posedge clk) begin
    #1;
    if (a_rnd) a_rdy = 1'($urandom_range(0, 1));
  end

  // ---------------- instance B: SS_LEN=256, RD_LAT=1 ----------------
  logic       b_start = 0, b_abort = 0, b_rdy = 0, b_rnd = 0;
  logic [7:0] b_ss_addr, b_din, b_dout;
  logic       b_ss_rd, b_vld, b_busy, b_done;
  logic [7:0] b_mem [256];
  logic       b_rd1 = 0;
  logic [7:0] b_ad1 = 0;
  logic [7:0] b_rd_q[$], b_rx_q[$];
  int         b_done_n = 0;
`ifdef SS_READER_CRC_EN
  logic [7:0] b_crc, b_crc_done;
`endif

  map_ss_reader #(.SS_LEN(256), .RD_LAT(1), .FIFO_DEPTH(4)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .start    (b_start),
    .abort    (b_abort),
    .ss_addr  (b_ss_addr),
    .ss_rd    (b_ss_rd),
    .ss_din   (b_din),
    .dout     (b_dout),
    .dout_vld (b_vld),
    .dout_rdy (b_rdy),
    .busy     (b_busy),
    .done     (b_done)
`ifdef SS_READER_CRC_EN
    ,
    .crc      (b_crc)
`endif
  );

  always @(posedge clk) begin
    b_rd1 <= b_ss_rd;
    b_ad1 <= b_ss_addr;
  end
  assign b_din = b_rd1 ? b_mem[b_ad1] : ~b_mem[b_ad1];

  always @(negedge clk) begin
    if (b_ss_rd) b_rd_q.push_back(b_ss_addr);
    if (b_vld && b_rdy) b_rx_q.push_back(b_dout);
    if (b_done) begin
      b_done_n++;
`ifdef SS_READER_CRC_EN
      b_crc_done = b_crc;
`endif
    end
  end

  always @(posedge clk) begin
    #1;
    if (b_rnd) b_rdy = 1'($urandom_range(0, 1));
  end

  // ---------------- helpers ----------------
  task automatic clr_a();
    a_rd_q.delete();
    a_rx_q.delete();
    a_done_n = 0;
  endtask

  task automatic start_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  task automatic wait_idle_a(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!a_busy) break;
      step();
    end
    check_eq("a_idle", int'(a_busy), 0);
  endtask

  // Expected: one read per address 0..3 in order, bytes in address order, one done.
  task automatic check_a(input string tag);
    logic [7:0] exp_q[$];
    for (int i = 0; i < 4; i++) exp_q.push_back(a_mem[i]);
    check_eq({tag, "_rd_len"}, a_rd_q.size(), 4);
    check_eq({tag, "_rx_len"}, a_rx_q.size(), 4);
    for (int i = 0; i < 4 && i < a_rd_q.size(); i++)
      check_eq({tag, "_addr"}, int'(a_rd_q[i]), i);
    for (int i = 0; i < 4 && i < a_rx_q.size(); i++)
      check_eq({tag, "_byte"}, int'(a_rx_q[i]), int'(exp_q[i]));
    check_eq({tag, "_done_n"}, a_done_n, 1);
    check_eq({tag, "_vld_end"}, int'(a_vld), 0);
`ifdef SS_READER_CRC_EN
    check_eq({tag, "_crc_done"}, int'(a_crc_done), int'(crc_model(exp_q)));
    check_eq({tag, "_crc_hold"}, int'(a_crc), int'(crc_model(exp_q)));
`endif
  endtask

  initial begin
    int mis, cyc;
    logic [7:0] exp_q[$];

    foreach (a_mem[i]) a_mem[i] = 8'(i) ^ 8'h5A;
    foreach (b_mem[i]) b_mem[i] = 8'($urandom);

    // Reset: outputs low while rst is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_a_addr", int'(a_ss_addr), 0);
    check_eq("rst_a_rd",   int'(a_ss_rd), 0);
    check_eq("rst_a_vld",  int'(a_vld), 0);
    check_eq("rst_a_busy", int'(a_busy), 0);
    check_eq("rst_a_done", int'(a_done), 0);
    check_eq("rst_a_dout", int'(a_dout), 0);
    check_eq("rst_b_busy", int'(b_busy), 0);
`ifdef SS_READER_CRC_EN
    check_eq("rst_a_crc",  int'(a_crc), 8'hFF);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Basic dump, addr^0x5A, host always ready.
    a_rdy = 1'b1;
    clr_a();
    start_a();
    wait_idle_a(200);
    check_a("basic");
    check_eq("basic_b0", a_rx_q.size() > 0 ? int'(a_rx_q[0]) : -1, 8'h5A);

    // start held high throughout the dump, random data and backpressure.
    foreach (a_mem[i]) a_mem[i] = 8'($urandom);
    a_rnd = 1'b1;
    clr_a();
    a_start = 1'b1;
    step();
    for (int i = 0; i < 300; i++) begin
      if (!a_busy) break;
      step();
    end
    a_start = 1'b0;
    check_eq("hold_idle", int'(a_busy), 0);
    a_rnd = 1'b0;
    a_rdy = 1'b1;
    step();
    check_a("hold");

    // Known bytes 01..04 (CRC reference case when enabled).
    for (int i = 0; i < 4; i++) a_mem[i] = 8'(i + 1);
    clr_a();
    start_a();
    wait_idle_a(200);
    check_a("seq");

    // Abort one cycle after the third strobe, host stalled.
    foreach (a_mem[i]) a_mem[i] = 8'($urandom);
    a_rdy = 1'b0;
    clr_a();
    start_a();
    for (int i = 0; i < 50; i++) begin
      if (a_rd_q.size() >= 3) break;
      step();
    end
    check_eq("abort_rd3", a_rd_q.size(), 3);
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    check_eq("abort_vld", int'(a_vld), 0);
    check_eq("abort_busy", int'(a_busy), 0);
    a_rdy = 1'b1;
    repeat (20) step();
    check_eq("abort_rd_n", a_rd_q.size(), 3);
    check_eq("abort_done_n", a_done_n, 0);
    check_eq("abort_rx_n", a_rx_q.size(), 0);

    // Reset mid-dump behaves like abort.
    clr_a();
    start_a();
    for (int i = 0; i < 50; i++) begin
      if (a_rd_q.size() >= 2) break;
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("mrst_busy", int'(a_busy), 0);
    check_eq("mrst_rd", int'(a_ss_rd), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) step();
    check_eq("mrst_done_n", a_done_n, 0);
    check_eq("mrst_busy_end", int'(a_busy), 0);
    check_eq("mrst_vld_end", int'(a_vld), 0);

    // B: host stalled -> exactly FIFO_DEPTH reads then stall; then full 256-byte dump.
    b_rdy = 1'b0;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    repeat (30) step();
    check_eq("stall_rd_n", b_rd_q.size(), 4);
    check_eq("stall_busy", int'(b_busy), 1);
    check_eq("stall_vld", int'(b_vld), 1);
    b_rnd = 1'b1;
    cyc = 0;
    while (b_busy && cyc < 6000) begin
      step();
      cyc++;
    end
    b_rnd = 1'b0;
    check_eq("full_idle", int'(b_busy), 0);
    check_eq("full_rd_n", b_rd_q.size(), 256);
    check_eq("full_rx_n", b_rx_q.size(), 256);
    mis = 0;
    for (int i = 0; i < b_rd_q.size(); i++) if (b_rd_q[i] != 8'(i)) mis++;
    check_eq("full_addr_mis", mis, 0);
    check_eq("full_last_addr", b_rd_q.size() > 0 ? int'(b_rd_q[b_rd_q.size()-1]) : -1, 8'hFF);
    mis = 0;
    for (int i = 0; i < b_rx_q.size() && i < 256; i++) if (b_rx_q[i] != b_mem[i]) mis++;
    check_eq("full_data_mis", mis, 0);
    check_eq("full_done_n", b_done_n, 1);
    repeat (5) step();
    check_eq("full_no_wrap", b_rd_q.size(), 256);
`ifdef SS_READER_CRC_EN
    for (int i = 0; i < 256; i++) exp_q.push_back(b_mem[i]);
    check_eq("full_crc", int'(b_crc_done), int'(crc_model(exp_q)));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
